// File: rtl/mem_responder.sv
// Memory-side req/gnt/rvalid target backed by a word array, with programmable
// grant wait states and a fixed-latency in-order response pipeline.
module mem_responder #(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned GNT_WAIT   = 0,
    parameter int unsigned RVALID_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {StIdle, StWait} state_e;

    state_e                      r_state;
    state_e                      w_state_d;
    logic [3:0]                  r_cnt;
    logic [3:0]                  w_cnt_d;
    logic                        w_access;
    logic                        w_in_range;
    logic [AW-1:0]               w_idx;
    logic [31:0]                 w_rd_word;
    logic [31:0]                 r_mem [DEPTH];
    logic [RVALID_LAT-1:0]       r_vld;
    logic [RVALID_LAT-1:0][31:0] r_data;
    logic                        w_unused_addr;

    assign w_unused_addr = ^addr_i[1:0];
    assign w_idx         = addr_i[AW+1:2];
    assign w_in_range    = ~|addr_i[31:AW+2];
    // Nothing is accepted while reset is held, even with a combinational grant.
    assign w_access      = req_i & gnt_o & ~rst_i;
    assign w_rd_word     = (w_in_range && !we_i) ? r_mem[w_idx] : 32'h0;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        gnt_o     = 1'b0;
        if (GNT_WAIT == 0) begin
            gnt_o = req_i;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (req_i) begin
                        w_state_d = StWait;
                        w_cnt_d   = 4'd1;
                    end
                end
                StWait: begin
                    gnt_o = (r_cnt == 4'(GNT_WAIT));
                    // A dropped request abandons the wait without an access.
                    if (!req_i || gnt_o) begin
                        w_state_d = StIdle;
                        w_cnt_d   = 4'd0;
                    end else begin
                        w_cnt_d = r_cnt + 4'd1;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_access && we_i && w_in_range) begin
            for (int n = 0; n < 4; n++) begin
                if (be_i[n]) begin
                    r_mem[w_idx][8*n +: 8] <= wdata_i[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld  <= '0;
            r_data <= '0;
        end else begin
            r_vld[0]  <= w_access;
            r_data[0] <= w_access ? w_rd_word : 32'h0;
            for (int i = 1; i < int'(RVALID_LAT); i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    assign rvalid_o = r_vld[RVALID_LAT-1];
    assign rdata_o  = rvalid_o ? r_data[RVALID_LAT-1] : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three configurations checked every cycle against a
// transaction-level model, plus directed scenarios with literal expectations.
module tb_mem_responder;
    localparam int NI  = 3;
    localparam int DEP = 16;
    localparam int GW  [NI] = '{0, 2, 0};
    localparam int LAT [NI] = '{1, 2, 3};

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NI-1:0] req;
    logic [NI-1:0] we;
    logic [NI-1:0] gnt;
    logic [NI-1:0] rvalid;
    logic [3:0]    be    [NI];
    logic [31:0]   addr  [NI];
    logic [31:0]   wdata [NI];
    logic [31:0]   rdata [NI];

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          held   [NI];
    resp_t       rq     [NI][$];
    logic [31:0] mm     [NI][DEP];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(16), .GNT_WAIT(0), .RVALID_LAT(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
        .we_i(we[0]), .be_i(be[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0])
    );
    mem_responder #(.DEPTH(16), .GNT_WAIT(2), .RVALID_LAT(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
        .we_i(we[1]), .be_i(be[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1])
    );
    mem_responder #(.DEPTH(16), .GNT_WAIT(0), .RVALID_LAT(3)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .req_i(req[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
        .we_i(we[2]), .be_i(be[2]), .addr_i(addr[2]), .wdata_i(wdata[2]), .rdata_o(rdata[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: grant after the request has been held GW cycles; each access yields
    // one response LAT cycles later, reads from a plain word array.
    always @(negedge clk) begin
        logic        eg;
        logic        ev;
        logic [31:0] ed;
        int          idx;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                eg = (GW[i] == 0) ? req[i] : 1'b0;
                ev = 1'b0;
                rq[i].delete();
                held[i] = 0;
            end else begin
                eg = req[i] && (held[i] == GW[i]);
                ev = (rq[i].size() > 0) && (rq[i][0].due == cyc);
            end
            ed = ev ? rq[i][0].data : 32'h0;
            chk($sformatf("u%0d.gnt", i), gnt[i], eg);
            chk($sformatf("u%0d.rvalid", i), rvalid[i], ev);
            chk($sformatf("u%0d.rdata", i), rdata[i], ed);
            if (ev) void'(rq[i].pop_front());
            if (!rst) begin
                if (req[i] && eg) begin
                    idx = int'(addr[i] >> 2);
                    if (we[i]) begin
                        if (idx < DEP) begin
                            for (int n = 0; n < 4; n++) begin
                                if (be[i][n]) mm[i][idx][8*n +: 8] = wdata[i][8*n +: 8];
                            end
                        end
                        rq[i].push_back('{cyc + LAT[i], 32'h0});
                    end else begin
                        rq[i].push_back('{cyc + LAT[i], (idx < DEP) ? mm[i][idx] : 32'h0});
                    end
                    held[i] = 0;
                end else if (req[i]) begin
                    held[i]++;
                end else begin
                    held[i] = 0;
                end
            end
        end
    end

    task automatic issue(input int i, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        @(posedge clk);
        #1;
        req[i]   = 1'b1;
        we[i]    = w;
        addr[i]  = a;
        be[i]    = b;
        wdata[i] = d;
        @(negedge clk);
    endtask

    task automatic release_req(input int i);
        @(posedge clk);
        #1;
        req[i] = 1'b0;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req = '0;
        we  = '0;
        for (int i = 0; i < NI; i++) begin
            be[i]    = 4'h0;
            addr[i]  = 32'h0;
            wdata[i] = 32'h0;
        end
        @(negedge clk);
        chk("reset.gnt1", gnt[1], 1'b0);
        chk("reset.rvalid2", rvalid[2], 1'b0);
        chk("reset.rdata2", rdata[2], 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic write then read.
        issue(0, 1'b1, 32'h10, 4'hF, 32'hA5A5_1234);
        chk("basic.wr_gnt", gnt[0], 1'b1);
        release_req(0);
        chk("basic.wr_rvalid", rvalid[0], 1'b1);
        chk("basic.wr_rdata", rdata[0], 32'h0);
        chk("basic.model", mm[0][4], 32'hA5A5_1234);
        issue(0, 1'b0, 32'h10, 4'h0, 32'h0);
        chk("basic.rd_gnt", gnt[0], 1'b1);
        release_req(0);
        chk("basic.rd_rvalid", rvalid[0], 1'b1);
        chk("basic.rd_rdata", rdata[0], 32'hA5A5_1234);

        // Byte enables.
        issue(0, 1'b1, 32'h20, 4'hF, 32'h0);
        issue(0, 1'b1, 32'h20, 4'b0101, 32'hFFFF_FFFF);
        issue(0, 1'b0, 32'h20, 4'h0, 32'h0);
        release_req(0);
        chk("be.rdata", rdata[0], 32'h00FF_00FF);
        chk("be.model", mm[0][8], 32'h00FF_00FF);

        // Out of range: write dropped, read returns 0, word 0 untouched.
        issue(0, 1'b1, 32'h00, 4'hF, 32'h1111_2222);
        issue(0, 1'b1, 32'h40, 4'hF, 32'hDEAD_BEEF);
        chk("oor.wr_gnt", gnt[0], 1'b1);
        issue(0, 1'b0, 32'h40, 4'h0, 32'h0);
        chk("oor.rd_gnt", gnt[0], 1'b1);
        issue(0, 1'b0, 32'h00, 4'h0, 32'h0);
        chk("oor.rd_rvalid", rvalid[0], 1'b1);
        chk("oor.rd_rdata", rdata[0], 32'h0);
        release_req(0);
        chk("oor.word0", rdata[0], 32'h1111_2222);

        // Wait states: gnt at t+2, rvalid at t+4.
        issue(1, 1'b1, 32'h4, 4'hF, 32'hCAFE_0001);
        chk("wait.gnt_t0", gnt[1], 1'b0);
        tick();
        chk("wait.gnt_t1", gnt[1], 1'b0);
        tick();
        chk("wait.gnt_t2", gnt[1], 1'b1);
        release_req(1);
        chk("wait.rvalid_t3", rvalid[1], 1'b0);
        tick();
        chk("wait.rvalid_t4", rvalid[1], 1'b1);
        issue(1, 1'b0, 32'h4, 4'h0, 32'h0);
        tick();
        tick();
        chk("wait.rd_gnt", gnt[1], 1'b1);
        release_req(1);
        tick();
        chk("wait.rd_rdata", rdata[1], 32'hCAFE_0001);
        // Dropped request: no grant, no response.
        issue(1, 1'b0, 32'h4, 4'h0, 32'h0);
        release_req(1);
        chk("drop.gnt", gnt[1], 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("drop.rvalid", rvalid[1], 1'b0);
        end

        // Pipelining at 1 access/cycle, latency 3.
        for (int k = 0; k < 4; k++) issue(2, 1'b1, 32'(4 * k), 4'hF, 32'(32'h100 + k));
        for (int k = 0; k < 4; k++) issue(2, 1'b0, 32'(4 * k), 4'h0, 32'h0);
        chk("pipe.d0", rdata[2], 32'h100);
        release_req(2);
        chk("pipe.d1", rdata[2], 32'h101);
        tick();
        chk("pipe.d2", rdata[2], 32'h102);
        tick();
        chk("pipe.d3", rdata[2], 32'h103);
        tick();
        chk("pipe.idle", rvalid[2], 1'b0);

        // Reset with three reads in flight and one request waiting.
        issue(2, 1'b0, 32'h0, 4'h0, 32'h0);
        issue(2, 1'b0, 32'h4, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        addr[2] = 32'h8;
        req[1]  = 1'b1;
        we[1]   = 1'b0;
        addr[1] = 32'h4;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        req[2] = 1'b0;
        @(negedge clk);
        chk("rst.rvalid", rvalid[2], 1'b0);
        chk("rst.rdata", rdata[2], 32'h0);
        chk("rst.gnt", gnt[1], 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst.post_gnt0", gnt[1], 1'b0);
        tick();
        chk("rst.post_gnt1", gnt[1], 1'b0);
        tick();
        chk("rst.post_gnt2", gnt[1], 1'b1);
        release_req(1);
        chk("rst.stale", rvalid[2], 1'b0);
        tick();
        chk("rst.new_rdata", rdata[1], 32'hCAFE_0001);
        issue(2, 1'b0, 32'hC, 4'h0, 32'h0);
        release_req(2);
        tick();
        tick();
        chk("rst.new_pipe", rdata[2], 32'h103);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
